// File: rtl/fifo_pkg.sv
// Shared types and helpers for the SRAM-backed FIFO (read and write sides).
package fifo_pkg;
  localparam int FIFO_DATA_W = 32;
  localparam int FIFO_ADDR_W = 4;

  typedef logic [FIFO_ADDR_W:0]   ptr_t;
  typedef logic [FIFO_ADDR_W-1:0] addr_t;
  typedef logic [FIFO_DATA_W-1:0] data_t;

  // Pointers carry a wrap bit, so plain modular subtraction gives the occupancy.
  function automatic ptr_t ptr_diff(input ptr_t a, input ptr_t b);
    return a - b;
  endfunction
endpackage

// File: rtl/fifo_skid2.sv
// Two-entry output buffer that absorbs the SRAM read latency; entry 0 is the head.
module fifo_skid2
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic [1:0]        o_cnt
);

  logic [DATA_W-1:0] r_e0;
  logic [DATA_W-1:0] r_e1;
  logic [1:0]        r_cnt;

  // Caller guarantees no push into a full buffer and no pop from an empty one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_e0  <= '0;
      r_e1  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_e0 <= i_data;
          else               r_e1 <= i_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_e0  <= r_e1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd2) begin
            r_e0 <= r_e1;
            r_e1 <= i_data;
          end else begin
            r_e0 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head = r_e0;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/fifo_read_port.sv
// Consumer end of the SRAM FIFO: issues credited SRAM reads and streams entries out.
module fifo_read_port
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   wr_ptr,
  input  logic              flush,
  output logic [ADDR_W:0]   rd_ptr,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_rd_addr,
  input  logic [DATA_W-1:0] sram_rd_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              empty,
  output logic [ADDR_W+1:0] level
);

  logic [ADDR_W:0] r_rd_ptr;
  logic            r_inflight;
  logic [1:0]      w_cnt;
  logic            w_pop;
  logic            w_issue;
  logic            w_sram_empty;
  logic [2:0]      w_credit;
  logic [ADDR_W:0] w_sram_lvl;

  // Full-width compare: equal low bits with differing wrap bit means full.
  assign w_sram_empty = (r_rd_ptr == wr_ptr);
  assign w_pop        = m_valid && m_ready;
  assign w_credit     = {1'b0, w_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue      = !rst && !flush && !w_sram_empty && (w_credit < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_inflight <= 1'b0;
    end else if (flush) begin
      r_rd_ptr   <= wr_ptr;
      r_inflight <= 1'b0;
    end else begin
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_inflight <= w_issue;
    end
  end

  // A read returning during a flush is dropped by the buffer's clear.
  fifo_skid2 #(.DATA_W(DATA_W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (flush),
    .i_push (r_inflight),
    .i_data (sram_rd_data),
    .i_pop  (w_pop),
    .o_head (m_data),
    .o_cnt  (w_cnt)
  );

  assign w_sram_lvl   = wr_ptr - r_rd_ptr;
  assign level        = {1'b0, w_sram_lvl}
                      + {{(ADDR_W+1){1'b0}}, r_inflight}
                      + {{ADDR_W{1'b0}}, w_cnt};
  assign empty        = (level == '0);
  assign m_valid      = (w_cnt != 2'd0);
  assign rd_ptr       = r_rd_ptr;
  assign sram_rd_en   = w_issue;
  assign sram_rd_addr = r_rd_ptr[ADDR_W-1:0];

endmodule

// File: tb/tb_fifo_read_port.sv
// Directed bench for fifo_read_port with a behavioural writer and sync-read SRAM.
module tb_fifo_read_port;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, m_ready;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          sram_rd_en;
  logic [AW-1:0] sram_rd_addr;
  logic [DW-1:0] sram_rd_data = '0;
  logic [DW-1:0] m_data;
  logic          m_valid, empty;
  logic [AW+1:0] level;

  logic [DW-1:0] mem [16];
  int n_tests = 0;
  int n_fail  = 0;
  int n_issue = 0;

  typedef struct {
    bit          wr;
    logic [31:0] wd;
    bit          rdy;
    bit          fl;
    bit          e_rden;
    logic [3:0]  e_addr;
    bit          e_vld;
    logic [31:0] e_data;
    int          e_lvl;
    int          e_rptr;
  } vec_t;
  vec_t tv [10];

  fifo_read_port #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .wr_ptr(wr_ptr), .flush(flush), .rd_ptr(rd_ptr),
    .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .empty(empty), .level(level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];
  always @(posedge clk) if (sram_rd_en) n_issue++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Writer-side assumptions: step of at most 1, never more than depth ahead.
  logic [AW:0] last_wr = '0;
  always @(posedge clk) begin
    logic [AW:0] d_step, d_occ;
    d_step = wr_ptr - last_wr;
    d_occ  = wr_ptr - rd_ptr;
    if (!rst && (d_step > 1 || d_occ > 16)) begin
      n_fail++;
      $display("FAIL writer_assume: step %0d occ %0d", d_step, d_occ);
    end
    last_wr = wr_ptr;
  end

  // Output must hold while stalled; buffer never over two entries.
  bit          hold_q = 1'b0;
  logic [31:0] hold_d = '0;
  always @(negedge clk) begin
    #2;
    if (hold_q && !rst) begin
      n_tests++;
      if (!m_valid || m_data !== hold_d) begin
        n_fail++;
        $display("FAIL hold_stable: got v=%0b d=%0h expected v=1 d=%0h", m_valid, m_data, hold_d);
      end
    end
    hold_q = m_valid && !m_ready && !flush && !rst;
    hold_d = m_data;
    if (dut.u_skid.o_cnt > 2'd2) begin
      n_fail++;
      $display("FAIL buf_cnt: got %0d expected <=2", dut.u_skid.o_cnt);
    end
  end

  task automatic cyc(input bit wr, input logic [31:0] wd, input bit rdy, input bit fl);
    @(negedge clk);
    if (wr) begin
      mem[wr_ptr[AW-1:0]] = wd;
      wr_ptr = wr_ptr + 1'b1;
    end
    m_ready = rdy;
    flush   = fl;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_ptr = '0; flush = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_issue = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; wr_ptr = '0; flush = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // 1. reset then idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    chk("rst_rdptr", rd_ptr, 0);
    for (int c = 0; c < 3; c++) begin
      cyc(0, 0, 0, 0);
      chk("idle_rden", sram_rd_en, 0);
      chk("idle_valid", m_valid, 0);
    end

    // 2. single entries, second one stalled for three cycles
    tv[0] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 32'h0,        1, 0};
    tv[1] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0,        1, 1};
    tv[2] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 32'hDEADBEEF, 1, 1};
    tv[3] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0,        0, 1};
    tv[4] = '{1'b1, 32'hA5A50001, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 32'h0,        1, 1};
    tv[5] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0,        1, 2};
    tv[6] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 32'hA5A50001, 1, 2};
    tv[7] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 32'hA5A50001, 1, 2};
    tv[8] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 32'hA5A50001, 1, 2};
    tv[9] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0,        0, 2};
    for (int i = 0; i < 10; i++) begin
      cyc(tv[i].wr, tv[i].wd, tv[i].rdy, tv[i].fl);
      chk($sformatf("v%0d_rden", i), sram_rd_en, tv[i].e_rden);
      if (tv[i].e_rden) chk($sformatf("v%0d_addr", i), sram_rd_addr, tv[i].e_addr);
      chk($sformatf("v%0d_valid", i), m_valid, tv[i].e_vld);
      if (tv[i].e_vld) chk($sformatf("v%0d_data", i), m_data, tv[i].e_data);
      chk($sformatf("v%0d_level", i), level, tv[i].e_lvl);
      chk($sformatf("v%0d_empty", i), empty, tv[i].e_lvl == 0);
      chk($sformatf("v%0d_rdptr", i), rd_ptr, tv[i].e_rptr);
    end

    // 3. full-rate burst of 20 with address wrap
    do_reset();
    for (int c = 0; c < 23; c++) begin
      cyc(c < 20, c, 1, 0);
      chk("burst_valid", m_valid, (c >= 2 && c < 22));
      if (c >= 2 && c < 22) chk("burst_data", m_data, c - 2);
      chk("burst_rdptr", rd_ptr, (c < 20) ? c : 20);
      chk("burst_rden", sram_rd_en, c < 20);
      if (c < 20) chk("burst_addr", sram_rd_addr, c % 16);
    end
    chk("burst_empty", empty, 1);
    chk("burst_level", level, 0);

    // 4. backpressure up to a completely full SRAM, then drain
    do_reset();
    for (int i = 0; i < 18; i++) cyc(1, 32'h100 + i, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    chk("bp_issues", n_issue, 2);
    chk("bp_rdptr", rd_ptr, 2);
    chk("bp_wrptr", wr_ptr, 18);
    chk("bp_level", level, 18);
    chk("bp_empty", empty, 0);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 32'h100);
    chk("bp_rden", sram_rd_en, 0);
    k = 0;
    for (int c = 0; c < 60 && k < 18; c++) begin
      cyc(0, 0, 1, 0);
      if (m_valid) begin
        chk("bp_drain_data", m_data, 32'h100 + k);
        k++;
      end
    end
    chk("bp_drain_count", k, 18);
    cyc(0, 0, 1, 0);
    chk("bp_end_empty", empty, 1);
    chk("bp_end_rdptr", rd_ptr, 18);

    // 5. alternating m_ready
    do_reset();
    k = 0;
    for (int c = 0; c < 80 && k < 8; c++) begin
      cyc(c < 8, 32'h200 + c, (c % 2) == 0, 0);
      if (m_valid && m_ready) begin
        chk("alt_data", m_data, 32'h200 + k);
        k++;
      end
    end
    chk("alt_count", k, 8);
    cyc(0, 0, 1, 0);
    chk("alt_valid_after", m_valid, 0);
    chk("alt_empty", empty, 1);

    // 6. flush with a read in flight and a buffered entry
    do_reset();
    cyc(1, 32'h300, 0, 0);
    cyc(1, 32'h301, 0, 0);
    cyc(1, 32'h302, 1, 1);
    chk("fl_rden_forced", sram_rd_en, 0);
    cyc(0, 0, 1, 0);
    chk("fl_valid", m_valid, 0);
    chk("fl_level", level, 0);
    chk("fl_rdptr", rd_ptr, 3);
    chk("fl_empty", empty, 1);
    cyc(1, 32'h55, 1, 0);
    chk("fl_reissue_addr", sram_rd_addr, 3);
    k = 0;
    for (int c = 0; c < 10 && k == 0; c++) begin
      cyc(0, 0, 1, 0);
      if (m_valid) begin
        chk("fl_next_beat", m_data, 32'h55);
        k = 1;
      end
    end
    chk("fl_beat_seen", k, 1);

    // Reset while a read is in flight: the returning word must be dropped.
    cyc(1, 32'h66, 0, 0);
    @(negedge clk);
    rst = 1'b1; wr_ptr = '0;
    #1;
    chk("mrst_rden", sram_rd_en, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_valid", m_valid, 0);
    chk("mrst_rdptr", rd_ptr, 0);
    cyc(0, 0, 0, 0);
    chk("mrst_valid2", m_valid, 0);
    chk("mrst_level", level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_read_port.md
Name: fifo_read_port

Overview:
- Read-side controller for the SRAM-backed FIFO: the consumer end of the FIFO's writer/SRAM pair.
- Compares its read pointer against the writer's pointer to detect empty.
- Issues synchronous reads to the dual-port block SRAM, absorbs the 1-cycle read latency in a 2-entry skid buffer, and presents entries on a valid/ready stream.
- Publishes its read pointer so the write side can compute full.

Parameters:
- DATA_W, 32, width of one FIFO entry / SRAM word
- ADDR_W, 4, SRAM address width; depth = 2**ADDR_W

Ports:
- clk  in  1  single clock; writer, SRAM and this block share it
- rst  in  1  synchronous, active-high reset
- wr_ptr  in  ADDR_W+1  writer pointer, binary; MSB is the wrap bit
- flush  in  1  synchronous discard of all unread data
- rd_ptr  out  ADDR_W+1  read pointer (entries released to writer)
- sram_rd_en  out  1  SRAM read enable
- sram_rd_addr  out  ADDR_W  SRAM read address = rd_ptr[ADDR_W-1:0]
- sram_rd_data  in  DATA_W  SRAM read data, valid the cycle after sram_rd_en
- m_valid  out  1  output entry valid
- m_data  out  DATA_W  output entry
- m_ready  in  1  consumer accepts when m_valid && m_ready
- empty  out  1  no entry in SRAM or in flight or buffered
- level  out  ADDR_W+2  total unread entries (SRAM + in flight + buffer)

Behaviour:
- Reset (rst=1 at posedge): rd_ptr=0, in-flight flag=0, buffer count=0, m_valid=0, m_data=0, sram_rd_en=0, empty=1, level=0.
- sram_empty = (rd_ptr == wr_ptr), full (ADDR_W+1)-bit compare. Equal low bits with different MSB means the SRAM is full, not empty.
- Credit rule: issue = !sram_empty && (buf_cnt + inflight - pop) < 2, where pop = m_valid && m_ready. This allows one read per cycle at full throughput with no overflow.
- sram_rd_en is combinational = issue, with sram_rd_addr = rd_ptr low bits. On issue, rd_ptr increments at the same posedge; natural wrap at 2**(ADDR_W+1).
- inflight <= issue. When inflight=1, sram_rd_data is written into the buffer tail at that posedge.
- Buffer: 2 entries, FIFO order. m_valid = (buf_cnt != 0), m_data = head entry.
  - buf_cnt next = buf_cnt + inflight - pop, range 0..2.
  - Simultaneous capture and pop when buf_cnt=1: head is replaced by incoming data, count stays 1.
- Latency: entry written at cycle N (wr_ptr advances at edge N) → issue in cycle N+1 → m_valid in cycle N+2 at the earliest.
- Throughput: with m_ready held 1, one entry per cycle sustained.
- Backpressure: m_ready=0 with buffer full (2) → issue=0. m_valid and m_data are held stable until accepted; they never change while m_valid && !m_ready.
- Release: rd_ptr advances at issue. The SRAM samples the address at that edge, so a writer reusing that slot in the following cycle is safe.
- level = (wr_ptr - rd_ptr), mod 2**(ADDR_W+1), + inflight + buf_cnt. empty = (level == 0).
- flush=1 at posedge:
  - rd_ptr <= wr_ptr, buf_cnt <= 0, inflight <= 0; the in-flight word is discarded.
  - m_valid is 0 the next cycle and issue is forced 0 during the flush cycle.
  - rst has priority over flush.
- Reset mid-stream: all state cleared as above. Any read returning in the cycle after rst is ignored.
- wr_ptr is assumed to step by at most 1 per cycle and never to pass rd_ptr + 2**ADDR_W. The bench asserts this; the RTL does not check it.

Decomposition:
- Shared package fifo_pkg:
  - ADDR_W and DATA_W defaults
  - ptr_t (ADDR_W+1 bits), addr_t, data_t typedefs
  - function ptr_diff(a, b) returning the modular difference, shared with the write side for full/level
- Sub-module fifo_skid2: the 2-entry output buffer, with push/data_in, pop, head, and count. All other logic stays in fifo_read_port.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, wr_ptr=0 → m_valid=0, empty=1, level=0, rd_ptr=0, sram_rd_en never asserted.
2. Single entry: wr_ptr 0→1 at cycle 5 with SRAM[0]=0xDEADBEEF, m_ready=1 → sram_rd_en=1 addr 0 at cycle 6; m_valid=1, m_data=0xDEADBEEF at cycle 7; empty=1 at cycle 8; rd_ptr=1.
3. Full-rate burst and wrap (ADDR_W=4): 20 entries 0..19 written one per cycle, m_ready=1 → 20 consecutive output beats 0..19 with no gaps; rd_ptr goes 0x0F→0x10→…→0x14; sram_rd_addr wraps 15→0.
4. Backpressure: 16 entries stored (wr_ptr=0x10, rd_ptr=0, full), m_ready=0 → exactly 2 reads issued, level=16, m_data is entry 0 and stable; then m_ready=1 → 16 beats in order, empty=1.
5. Alternating m_ready 1,0,1,0 over 8 entries → 8 beats in order, no duplicates or losses, buf_cnt never exceeds 2.
6. Flush with a read in flight and buffer=2 → next cycle m_valid=0, level=0, rd_ptr=wr_ptr; a subsequent write of 0x55 is the next beat out.
